// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants, RV32I opcode values and FSM state type for the fetch front end
package fetch_pkg;
    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [6:0]  OP_RTYPE  = 7'b0110011;
    localparam logic [6:0]  OP_ITYPE  = 7'b0010011;
    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, HALT} fetch_state_t;
endpackage

// File: rtl/fetch_if.sv
// fetch_if: instruction memory request/response, decode handoff and branch redirect bundle
interface fetch_if #(parameter int XLEN = 32);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;
    logic            instr_valid;
    logic            instr_ready;
    logic [31:0]     instr;
    logic [XLEN-1:0] instr_pc;
    logic [6:0]      op;
    logic [2:0]      funct3;
    logic            funct7;
    logic            redirect;
    logic [XLEN-1:0] redirect_target;
    logic            misalign;

    modport master (
        output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc, op, funct3, funct7, misalign,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready, redirect, redirect_target
    );
    modport slave (
        input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc, op, funct3, funct7, misalign,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready, redirect, redirect_target
    );
endinterface

// File: rtl/fetch_buffer.sv
// fetch_buffer: power-of-2 deep sync FIFO of {pc, instr} with flush and occupancy count
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 2,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [XLEN-1:0]          push_pc,
    input  logic [31:0]              push_instr,
    output logic [XLEN-1:0]          head_pc,
    output logic [31:0]              head_instr,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [XLEN-1:0] pc_mem  [DEPTH];
    logic [31:0]     ins_mem [DEPTH];
    logic [AW-1:0]   wr, rd;

    assign head_pc    = pc_mem[rd];
    assign head_instr = ins_mem[rd];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]  <= RESET_PC;
                ins_mem[i] <= NOP_INSTR;
            end
            wr    <= '0;
            rd    <= '0;
            count <= '0;
        end else if (flush) begin
            wr    <= '0;
            rd    <= '0;
            count <= '0;
        end else begin
            if (push) begin
                pc_mem[wr]  <= push_pc;
                ins_mem[wr] <= push_instr;
            end
            wr    <= push ? wr + AW'(1) : wr;
            rd    <= pop ? rd + AW'(1) : rd;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: RV32I fetch front end - PC, credit-limited imem requests, buffered decode handoff.
// FETCH_MISALIGN_TRAP_EN: misaligned redirect targets raise a sticky misalign flag and halt fetch.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              BUF_DEPTH = 2
) (
    input logic     clk,
    input logic     rst_n,
    fetch_if.master bus
);
    localparam int CW = $clog2(BUF_DEPTH) + 1;

    fetch_state_t    state;
    logic [CW-1:0]   credit, stale, count, credit_n, count_n;
    logic [CW:0]     load_n;
    logic [XLEN-1:0] fetch_pc, rsp_pc, target, head_pc;
    logic [31:0]     head_instr;
    logic            req_valid, acc, rsp, pop, rd, push, bad;

    assign acc      = req_valid && bus.imem_req_ready;
    assign rsp      = bus.imem_rsp_valid;
    assign pop      = bus.instr_valid && bus.instr_ready;
    assign rd       = pop && bus.redirect;
    assign push     = rsp && state == RUN && !rd;
    assign credit_n = credit + CW'(acc) - CW'(rsp);
    assign count_n  = rd ? '0 : count + CW'(push) - CW'(pop);
    // outstanding requests plus buffered words can never exceed the buffer, so pushes always fit
    assign load_n   = {1'b0, credit_n} + {1'b0, count_n};

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misalign;
    assign target = bus.redirect_target;
    assign bad    = rd && target[1:0] != 2'b00;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) misalign <= 1'b0;
        else        misalign <= misalign || bad;
    end
    assign bus.misalign = misalign;
`else
    assign target       = bus.redirect_target & ~XLEN'(3);
    assign bad          = 1'b0;
    assign bus.misalign = 1'b0;
`endif

    fetch_buffer #(.XLEN(XLEN), .DEPTH(BUF_DEPTH), .RESET_PC(RESET_PC)) u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .pop        (pop),
        .flush      (rd),
        .push_pc    (rsp_pc),
        .push_instr (bus.imem_rsp_data),
        .head_pc    (head_pc),
        .head_instr (head_instr),
        .count      (count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_valid <= 1'b0;
            credit    <= '0;
            stale     <= '0;
            fetch_pc  <= RESET_PC;
            rsp_pc    <= RESET_PC;
        end else begin
            credit    <= credit_n;
            req_valid <= state != HALT && !bad && load_n < (CW+1)'(BUF_DEPTH);
            fetch_pc  <= rd ? target : acc ? fetch_pc + XLEN'(4) : fetch_pc;
            // rsp_pc tracks the address of the next fresh response; stale drops leave it alone
            rsp_pc    <= rd ? target : push ? rsp_pc + XLEN'(4) : rsp_pc;
            case (state)
                IDLE: state <= RUN;
                RUN: begin
                    stale <= rd ? credit_n : stale;
                    state <= bad ? HALT : (rd && credit_n != '0) ? FLUSH : RUN;
                end
                FLUSH: begin
                    stale <= stale - CW'(rsp);
                    state <= stale == CW'(rsp) ? RUN : FLUSH;
                end
                default: state <= HALT;
            endcase
        end
    end

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = fetch_pc;
    assign bus.instr_valid    = count != '0;
    assign bus.instr          = head_instr;
    assign bus.instr_pc       = head_pc;
    assign bus.op             = head_instr[6:0];
    assign bus.funct3         = head_instr[14:12];
    assign bus.funct7         = head_instr[30];
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed scenarios against a latency-programmable in-order imem model
module tb_instr_fetch_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_if #(.XLEN(32)) bus ();

    instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .BUF_DEPTH(2)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad = 0;
    int lat = 1;
    int cyc = 0;
    logic [31:0] mq_addr[$];
    int          mq_due[$];
    logic [31:0] acc_q[$], pop_pc_q[$], pop_ins_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a << 12) | 32'h0050_0093;
    endfunction

    // in-order memory: a request accepted at edge n responds lat cycles later, one per cycle
    always @(posedge clk) begin
        if (!rst_n) begin
            mq_addr.delete();
            mq_due.delete();
            bus.imem_rsp_valid <= 1'b0;
            bus.imem_rsp_data  <= '0;
            cyc <= 0;
        end else begin
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                mq_addr.push_back(bus.imem_req_addr);
                mq_due.push_back(cyc + lat - 1);
                acc_q.push_back(bus.imem_req_addr);
            end
            if (bus.instr_valid && bus.instr_ready) begin
                pop_pc_q.push_back(bus.instr_pc);
                pop_ins_q.push_back(bus.instr);
            end
            if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
                bus.imem_rsp_valid <= 1'b1;
                bus.imem_rsp_data  <= mem_word(mq_addr[0]);
                void'(mq_addr.pop_front());
                void'(mq_due.pop_front());
            end else begin
                bus.imem_rsp_valid <= 1'b0;
            end
            cyc <= cyc + 1;
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        bus.imem_req_ready  = 1'b1;
        bus.instr_ready     = 1'b0;
        bus.redirect        = 1'b0;
        bus.redirect_target = '0;
        lat = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        acc_q.delete();
        pop_pc_q.delete();
        pop_ins_q.delete();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.imem_req_ready  = 1'b1;
        bus.instr_ready     = 1'b0;
        bus.redirect        = 1'b0;
        bus.redirect_target = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (bus.imem_req_valid !== 1'b0) begin bad++; $display("FAIL rst_req_valid got=%0h want=0", bus.imem_req_valid); end
        total++; if (bus.imem_req_addr !== 32'h0) begin bad++; $display("FAIL rst_req_addr got=%0h want=0", bus.imem_req_addr); end
        total++; if (bus.instr_valid !== 1'b0) begin bad++; $display("FAIL rst_instr_valid got=%0h want=0", bus.instr_valid); end
        total++; if (bus.instr !== 32'h0000_0013) begin bad++; $display("FAIL rst_instr got=%0h want=13", bus.instr); end
        total++; if (bus.instr_pc !== 32'h0) begin bad++; $display("FAIL rst_instr_pc got=%0h want=0", bus.instr_pc); end
        total++; if (bus.misalign !== 1'b0) begin bad++; $display("FAIL rst_misalign got=%0h want=0", bus.misalign); end
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++; if (bus.imem_req_valid !== 1'b0) begin bad++; $display("FAIL arst_req_valid got=%0h want=0", bus.imem_req_valid); end
        total++; if (bus.imem_req_addr !== 32'h0) begin bad++; $display("FAIL arst_req_addr got=%0h want=0", bus.imem_req_addr); end
        total++; if (bus.instr_valid !== 1'b0) begin bad++; $display("FAIL arst_instr_valid got=%0h want=0", bus.instr_valid); end
        total++; if (bus.instr !== 32'h0000_0013) begin bad++; $display("FAIL arst_instr got=%0h want=13", bus.instr); end
        @(negedge clk);
    endtask

    task automatic test_basic();
        do_reset();
        bus.instr_ready = 1'b1;
        @(negedge clk);
        total++; if (bus.imem_req_valid !== 1'b1) begin bad++; $display("FAIL basic_req_valid got=%0h want=1", bus.imem_req_valid); end
        total++; if (bus.imem_req_addr !== 32'h0) begin bad++; $display("FAIL basic_req_addr got=%0h want=0", bus.imem_req_addr); end
        @(negedge clk);
        total++; if (acc_q.size() != 1) begin bad++; $display("FAIL basic_first_accept got=%0d want=1", acc_q.size()); end
        total++; if (bus.instr_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%0h want=0", bus.instr_valid); end
        @(negedge clk);
        total++; if (bus.instr_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%0h want=1", bus.instr_valid); end
        total++; if (bus.instr_pc !== 32'h0) begin bad++; $display("FAIL basic_pc0 got=%0h want=0", bus.instr_pc); end
        total++; if (bus.instr !== 32'h0050_0093) begin bad++; $display("FAIL basic_instr got=%0h want=00500093", bus.instr); end
        total++; if (bus.op !== 7'b0010011) begin bad++; $display("FAIL basic_op got=%0h want=13", bus.op); end
        total++; if (bus.funct3 !== 3'd0) begin bad++; $display("FAIL basic_funct3 got=%0h want=0", bus.funct3); end
        total++; if (bus.funct7 !== 1'b0) begin bad++; $display("FAIL basic_funct7 got=%0h want=0", bus.funct7); end
        repeat (8) @(negedge clk);
        total++; if (acc_q.size() < 3 || pop_pc_q.size() < 3) begin
            bad++; $display("FAIL basic_count acc=%0d pop=%0d want>=3", acc_q.size(), pop_pc_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++; if (acc_q[i] !== 32'(i * 4)) begin bad++; $display("FAIL basic_req%0d got=%0h want=%0h", i, acc_q[i], i * 4); end
                total++; if (pop_pc_q[i] !== 32'(i * 4)) begin bad++; $display("FAIL basic_pc%0d got=%0h want=%0h", i, pop_pc_q[i], i * 4); end
                total++; if (pop_ins_q[i] !== mem_word(32'(i * 4))) begin bad++; $display("FAIL basic_ins%0d got=%0h want=%0h", i, pop_ins_q[i], mem_word(32'(i * 4))); end
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        repeat (10) @(negedge clk);
        total++; if (acc_q.size() != 2) begin bad++; $display("FAIL stall_accepts got=%0d want=2", acc_q.size()); end
        total++; if (bus.imem_req_valid !== 1'b0) begin bad++; $display("FAIL stall_req_valid got=%0h want=0", bus.imem_req_valid); end
        total++; if (bus.instr_valid !== 1'b1) begin bad++; $display("FAIL stall_valid got=%0h want=1", bus.instr_valid); end
        total++; if (bus.instr_pc !== 32'h0) begin bad++; $display("FAIL stall_head got=%0h want=0", bus.instr_pc); end
        bus.instr_ready = 1'b1;
        repeat (12) @(negedge clk);
        total++; if (pop_pc_q.size() < 4) begin bad++; $display("FAIL stall_drain got=%0d want>=4", pop_pc_q.size()); end
        for (int i = 0; i < pop_pc_q.size(); i++) begin
            total++; if (pop_pc_q[i] !== 32'(i * 4)) begin bad++; $display("FAIL stall_order%0d got=%0h want=%0h", i, pop_pc_q[i], i * 4); end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        @(negedge clk);
        @(negedge clk);
        lat = 5;
        @(negedge clk);
        total++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h0) begin bad++; $display("FAIL redir_head valid=%0h pc=%0h want=1/0", bus.instr_valid, bus.instr_pc); end
        total++; if (acc_q.size() != 2) begin bad++; $display("FAIL redir_inflight got=%0d want=2", acc_q.size()); end
        bus.redirect = 1'b1;
        bus.redirect_target = 32'h100;
        bus.instr_ready = 1'b1;
        @(negedge clk);
        bus.redirect = 1'b0;
        lat = 1;
        total++; if (bus.instr_valid !== 1'b0) begin bad++; $display("FAIL redir_flushed got=%0h want=0", bus.instr_valid); end
        total++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h100) begin bad++; $display("FAIL redir_req valid=%0h addr=%0h want=1/100", bus.imem_req_valid, bus.imem_req_addr); end
        repeat (8) @(negedge clk);
        total++; if (pop_pc_q.size() < 2) begin
            bad++; $display("FAIL redir_pops got=%0d want>=2", pop_pc_q.size());
        end else begin
            total++; if (pop_pc_q[0] !== 32'h0) begin bad++; $display("FAIL redir_pc0 got=%0h want=0", pop_pc_q[0]); end
            total++; if (pop_pc_q[1] !== 32'h100) begin bad++; $display("FAIL redir_pc1 got=%0h want=100", pop_pc_q[1]); end
            total++; if (pop_ins_q[1] !== mem_word(32'h100)) begin bad++; $display("FAIL redir_ins1 got=%0h want=%0h", pop_ins_q[1], mem_word(32'h100)); end
        end
        for (int i = 0; i < pop_pc_q.size(); i++) begin
            total++; if (pop_pc_q[i] === 32'h4) begin bad++; $display("FAIL redir_stale_pop%0d got=%0h want!=4", i, pop_pc_q[i]); end
        end
    endtask

    task automatic test_backpressure();
        logic pv, pr;
        logic [31:0] ppc;
        int events;
        do_reset();
        bus.instr_ready = 1'b1;
        repeat (3) @(negedge clk);
        bus.imem_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++; if (bus.imem_req_valid !== 1'b1) begin bad++; $display("FAIL bp_valid%0d got=%0h want=1", i, bus.imem_req_valid); end
            total++; if (bus.imem_req_addr !== 32'h8) begin bad++; $display("FAIL bp_addr%0d got=%0h want=8", i, bus.imem_req_addr); end
        end
        bus.imem_req_ready = 1'b1;
        events = 0;
        pv = bus.instr_valid;
        pr = bus.imem_rsp_valid;
        ppc = bus.instr_pc;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (pv && pr) begin
                events++;
                total++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== ppc + 32'h4) begin
                    bad++; $display("FAIL bp_pushpop%0d valid=%0h pc=%0h want=1/%0h", i, bus.instr_valid, bus.instr_pc, ppc + 32'h4);
                end
            end
            pv = bus.instr_valid;
            pr = bus.imem_rsp_valid;
            ppc = bus.instr_pc;
        end
        total++; if (events == 0) begin bad++; $display("FAIL bp_pushpop_seen got=0 want>0"); end
        for (int i = 0; i < pop_pc_q.size(); i++) begin
            total++; if (pop_pc_q[i] !== 32'(i * 4)) begin bad++; $display("FAIL bp_order%0d got=%0h want=%0h", i, pop_pc_q[i], i * 4); end
        end
    endtask

    task automatic test_wrap();
        int ia, ip;
        do_reset();
        bus.instr_ready = 1'b1;
        for (int k = 0; k < 20 && !bus.instr_valid; k++) @(negedge clk);
        total++; if (bus.instr_valid !== 1'b1) begin bad++; $display("FAIL wrap_wait got=%0h want=1", bus.instr_valid); end
        bus.redirect = 1'b1;
        bus.redirect_target = 32'hFFFF_FFFC;
        @(negedge clk);
        bus.redirect = 1'b0;
        repeat (16) @(negedge clk);
        ia = -1;
        ip = -1;
        for (int i = 0; i < acc_q.size(); i++) if (ia < 0 && acc_q[i] === 32'hFFFF_FFFC) ia = i;
        for (int i = 0; i < pop_pc_q.size(); i++) if (ip < 0 && pop_pc_q[i] === 32'hFFFF_FFFC) ip = i;
        total++; if (ia < 0 || ia + 1 >= acc_q.size()) begin
            bad++; $display("FAIL wrap_req_seen idx=%0d size=%0d want=ffff_fffc then 0", ia, acc_q.size());
        end else begin
            total++; if (acc_q[ia+1] !== 32'h0) begin bad++; $display("FAIL wrap_req got=%0h want=0", acc_q[ia+1]); end
        end
        total++; if (ip < 0 || ip + 1 >= pop_pc_q.size()) begin
            bad++; $display("FAIL wrap_pop_seen idx=%0d size=%0d want=ffff_fffc then 0", ip, pop_pc_q.size());
        end else begin
            total++; if (pop_pc_q[ip+1] !== 32'h0) begin bad++; $display("FAIL wrap_pc got=%0h want=0", pop_pc_q[ip+1]); end
            total++; if (pop_ins_q[ip+1] !== mem_word(32'h0)) begin bad++; $display("FAIL wrap_ins got=%0h want=%0h", pop_ins_q[ip+1], mem_word(32'h0)); end
        end
    endtask

    task automatic test_misalign();
        do_reset();
        bus.instr_ready = 1'b1;
        for (int k = 0; k < 20 && !bus.instr_valid; k++) @(negedge clk);
        total++; if (bus.instr_valid !== 1'b1) begin bad++; $display("FAIL mis_wait got=%0h want=1", bus.instr_valid); end
        bus.redirect = 1'b1;
        bus.redirect_target = 32'h102;
        @(negedge clk);
        bus.redirect = 1'b0;
        acc_q.delete();
        pop_pc_q.delete();
        pop_ins_q.delete();
        repeat (10) @(negedge clk);
`ifdef FETCH_MISALIGN_TRAP_EN
        total++; if (bus.misalign !== 1'b1) begin bad++; $display("FAIL mis_flag got=%0h want=1", bus.misalign); end
        total++; if (acc_q.size() != 0) begin bad++; $display("FAIL mis_reqs got=%0d want=0", acc_q.size()); end
        total++; if (bus.imem_req_valid !== 1'b0) begin bad++; $display("FAIL mis_req_valid got=%0h want=0", bus.imem_req_valid); end
        total++; if (bus.instr_valid !== 1'b0) begin bad++; $display("FAIL mis_instr_valid got=%0h want=0", bus.instr_valid); end
`else
        total++; if (bus.misalign !== 1'b0) begin bad++; $display("FAIL mis_flag got=%0h want=0", bus.misalign); end
        total++; if (acc_q.size() == 0 || acc_q[0] !== 32'h100) begin
            bad++; $display("FAIL mis_req size=%0d first=%0h want=100", acc_q.size(), acc_q.size() ? acc_q[0] : 32'hx);
        end
        total++; if (pop_pc_q.size() == 0 || pop_pc_q[0] !== 32'h100) begin
            bad++; $display("FAIL mis_pc size=%0d first=%0h want=100", pop_pc_q.size(), pop_pc_q.size() ? pop_pc_q[0] : 32'hx);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_redirect();
        test_backpressure();
        test_wrap();
        test_misalign();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
